fwd_sel_unit: RTL and testbench

- Generates the 2-bit select codes that drive the two ALU-operand 4:1 muxes in the EX stage of the 5-stage pipeline.
- It is the producer side of the mux select interface.
- Tracks destination-register state through ID/EX, EX/MEM and MEM/WB internally.
- Detects load-use hazards and raises a stall request to the IF/ID control logic.

---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_operand_sel.sv | 36 +++
 rtl/fwd_sel_unit.sv | 116 +++++++++++
 tb/tb_fwd_sel_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants for the EX-stage operand forwarding unit:
// default register index width, mux select encodings and bubble field values.
package fwd_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  // Operand mux select encodings, one per ALU operand mux input
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB_ALU  = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_WB_LOAD = 2'b11;

  // A bubble neither writes a register nor loads, so it can never match or stall
  localparam logic BUBBLE_RW = 1'b0;
  localparam logic BUBBLE_MR = 1'b0;

endpackage

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding decision: compares one EX source register against the
// EX/MEM and MEM/WB producers and priority-encodes the 2-bit mux select.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_rw,
  input  logic                  i_mem_mr,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_rw,
  input  logic                  i_wb_mr,
  output logic [1:0]            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_rw && (i_mem_rd == i_rs) && !(ZERO_REG_GUARD && (i_mem_rd == '0));
  assign w_wb_hit  = i_wb_rw  && (i_wb_rd  == i_rs) && !(ZERO_REG_GUARD && (i_wb_rd  == '0));

  // A load sitting in MEM has no data yet, so it is skipped and the WB/regfile
  // check decides; the newer EX/MEM producer otherwise always wins over MEM/WB.
  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit && !i_mem_mr) begin
      o_sel = FWD_EXMEM;
    end else if (w_wb_hit) begin
      o_sel = i_wb_mr ? FWD_WB_LOAD : FWD_WB_ALU;
    end
  end

endmodule

// File: rtl/fwd_sel_unit.sv
// EX-stage forwarding select generator: tracks destination state through
// ID/EX, EX/MEM and MEM/WB and raises a one-cycle load-use stall.
module fwd_sel_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  load_use_stall
);

  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_rw;
  logic                  r_ex_mr;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_rw;
  logic                  r_mem_mr;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_rw;
  logic                  r_wb_mr;

  logic w_rs1_hazard;
  logic w_rs2_hazard;
  logic w_load_use_stall;
  logic w_capture_id;

  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] rd,
                                     input logic                  rw,
                                     input logic [REG_ADDR_W-1:0] rs);
    return rw && (rd == rs) && !(ZERO_REG_GUARD && (rd == '0));
  endfunction

  // Stall is derived from registered EX state, so async reset drops it at once
  assign w_rs1_hazard     = reg_match(r_ex_rd, r_ex_rw, id_rs1);
  assign w_rs2_hazard     = reg_match(r_ex_rd, r_ex_rw, id_rs2);
  assign w_load_use_stall = r_ex_mr && (w_rs1_hazard || w_rs2_hazard);
  assign w_capture_id     = !w_load_use_stall && !flush;
  assign load_use_stall   = w_load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
      r_ex_rd  <= '0;
      r_ex_rw  <= BUBBLE_RW;
      r_ex_mr  <= BUBBLE_MR;
      r_mem_rd <= '0;
      r_mem_rw <= BUBBLE_RW;
      r_mem_mr <= BUBBLE_MR;
      r_wb_rd  <= '0;
      r_wb_rw  <= BUBBLE_RW;
      r_wb_mr  <= BUBBLE_MR;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;
      r_mem_mr <= r_ex_mr;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
      r_wb_mr  <= r_mem_mr;
      if (w_capture_id) begin
        r_ex_rs1 <= id_rs1;
        r_ex_rs2 <= id_rs2;
        r_ex_rd  <= id_rd;
        r_ex_rw  <= id_reg_write;
        r_ex_mr  <= id_mem_read;
      end else begin
        r_ex_rs1 <= '0;
        r_ex_rs2 <= '0;
        r_ex_rd  <= '0;
        r_ex_rw  <= BUBBLE_RW;
        r_ex_mr  <= BUBBLE_MR;
      end
    end
  end

  fwd_operand_sel #(
    .REG_ADDR_W     (REG_ADDR_W),
    .ZERO_REG_GUARD (ZERO_REG_GUARD)
  ) u_sel_a (
    .i_rs     (r_ex_rs1),
    .i_mem_rd (r_mem_rd),
    .i_mem_rw (r_mem_rw),
    .i_mem_mr (r_mem_mr),
    .i_wb_rd  (r_wb_rd),
    .i_wb_rw  (r_wb_rw),
    .i_wb_mr  (r_wb_mr),
    .o_sel    (fwd_a_sel)
  );

  fwd_operand_sel #(
    .REG_ADDR_W     (REG_ADDR_W),
    .ZERO_REG_GUARD (ZERO_REG_GUARD)
  ) u_sel_b (
    .i_rs     (r_ex_rs2),
    .i_mem_rd (r_mem_rd),
    .i_mem_rw (r_mem_rw),
    .i_mem_mr (r_mem_mr),
    .i_wb_rd  (r_wb_rd),
    .i_wb_rw  (r_wb_rw),
    .i_wb_mr  (r_wb_mr),
    .o_sel    (fwd_b_sel)
  );

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed self-checking bench for fwd_sel_unit: instruction sequences are fed
// into ID one per cycle and the EX-stage selects and stall are compared to hand values.
module tb_fwd_sel_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       load_use_stall;

  int checks;
  int failures;

  fwd_sel_unit #(
    .REG_ADDR_W     (5),
    .ZERO_REG_GUARD (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .flush          (flush),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Places one instruction in ID; it is captured into EX on the next rising edge
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw, input logic mr);
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expA,
                             input logic [1:0] expB, input logic expStall);
    checks++;
    assert (fwd_a_sel === expA) else begin
      failures++;
      $error("[TB] FAIL %s.fwd_a_sel observed=%b expected=%b", tag, fwd_a_sel, expA);
    end
    checks++;
    assert (fwd_b_sel === expB) else begin
      failures++;
      $error("[TB] FAIL %s.fwd_b_sel observed=%b expected=%b", tag, fwd_b_sel, expB);
    end
    checks++;
    assert (load_use_stall === expStall) else begin
      failures++;
      $error("[TB] FAIL %s.load_use_stall observed=%b expected=%b", tag, load_use_stall, expStall);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Reset held with random ID traffic and loads: nothing may leak through
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
      tick();
      checkOutput("reset_hold", 2'b00, 2'b00, 1'b0);
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // add x5,x1,x2 then unrelated add x6,x3,x4
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    applyStimulus(5'd3, 5'd4, 5'd6, 1'b1, 1'b0); tick();
    checkOutput("unrelated", 2'b00, 2'b00, 1'b0);

    // add x5,x1,x2 ; sub x6,x5,x3
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    applyStimulus(5'd5, 5'd3, 5'd6, 1'b1, 1'b0); tick();
    checkOutput("exmem_fwd", 2'b10, 2'b00, 1'b0);

    // add x5 ; nop ; or x7,x3,x5
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    applyStimulus(5'd3, 5'd5, 5'd7, 1'b1, 1'b0); tick();
    checkOutput("wb_fwd", 2'b00, 2'b01, 1'b0);

    // add x5 ; addi x5,x1 ; and x8,x5,x5
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    applyStimulus(5'd1, 5'd0, 5'd5, 1'b1, 1'b0); tick();
    applyStimulus(5'd5, 5'd5, 5'd8, 1'b1, 1'b0); tick();
    checkOutput("newest_wins", 2'b10, 2'b10, 1'b0);

    // lw x4,0(x1) ; add x9,x4,x4
    applyStimulus(5'd1, 5'd0, 5'd4, 1'b1, 1'b1); tick();
    applyStimulus(5'd4, 5'd4, 5'd9, 1'b1, 1'b0); #1;
    checkOutput("lu_stall", 2'b00, 2'b00, 1'b1);
    tick();
    checkOutput("lu_bubble", 2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("lu_wb_load", 2'b11, 2'b11, 1'b0);

    // add x0,x1,x2 ; sub x3,x0,x0
    applyStimulus(5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
    applyStimulus(5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();
    checkOutput("x0_fwd", 2'b00, 2'b00, 1'b0);

    // lw x0,0(x1) ; add x1,x0,x0
    applyStimulus(5'd1, 5'd0, 5'd0, 1'b1, 1'b1); tick();
    applyStimulus(5'd0, 5'd0, 5'd1, 1'b1, 1'b0); #1;
    checkOutput("x0_stall", 2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("x0_after", 2'b00, 2'b00, 1'b0);

    // Flush alone squashes add x11, so the dependent sub sees no producer
    applyStimulus(5'd1, 5'd2, 5'd11, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(5'd11, 5'd11, 5'd12, 1'b1, 1'b0); tick();
    checkOutput("flush_squash", 2'b00, 2'b00, 1'b0);

    // lw x4 ; add x9,x4,x4 with flush during the stall ; or x10,x9,x0
    applyStimulus(5'd1, 5'd0, 5'd4, 1'b1, 1'b1); tick();
    applyStimulus(5'd4, 5'd4, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", 2'b00, 2'b00, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_bubble", 2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("flush_add_ex", 2'b11, 2'b11, 1'b0);
    applyStimulus(5'd9, 5'd0, 5'd10, 1'b1, 1'b0); tick();
    checkOutput("flush_no_dup", 2'b10, 2'b00, 1'b0);

    // add x10 ; lw x4,0(x10) ; add x9,x4,x4 then reset mid-stall
    applyStimulus(5'd1, 5'd2, 5'd10, 1'b1, 1'b0); tick();
    applyStimulus(5'd10, 5'd0, 5'd4, 1'b1, 1'b1); tick();
    applyStimulus(5'd4, 5'd4, 5'd9, 1'b1, 1'b0); #1;
    checkOutput("pre_reset", 2'b10, 2'b00, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("reset_held", 2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    checkOutput("post_reset", 2'b00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
